// File: rtl/pyhdl_via_stream_capture_pkg.sv
// Shared types for the VIA stream-capture stage: FSM encoding, entry layout
// and the drop-counter width.
package pyhdl_via_capture_pkg;

  localparam int DROP_W     = 16;
  localparam int CAP_TS_W   = 32;
  localparam int CAP_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

  // Reference layout of one buffered beat; the FIFO stores {ts, data} packed in this order.
  typedef struct packed {
    logic [CAP_TS_W-1:0]   ts;
    logic [CAP_DATA_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/pyhdl_via_stream_capture_if.sv
// Monitored stream plus the FIFO drain port of the capture stage.
interface pyhdl_via_stream_capture_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32
);
  logic              mon_valid;
  logic              mon_ready;
  logic [DATA_W-1:0] mon_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [TS_W-1:0]   rd_ts;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output mon_valid, mon_ready, mon_data, rd_ready,
    input  rd_valid, rd_ts, rd_data
  );

  modport slave (
    input  mon_valid, mon_ready, mon_data, rd_ready,
    output rd_valid, rd_ts, rd_data
  );
endinterface

// File: rtl/pyhdl_via_stream_capture_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter and a
// synchronous flush that overrides push and pop.
module pyhdl_via_fwft_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign rd_valid = (level_reg != '0);
  assign full     = (level_reg == FULL_LEVEL);
  assign pop_ok   = pop && rd_valid;
  // When full, a push only fits if the head leaves on the same edge.
  assign push_ok  = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Head is zeroed while empty so stale storage never shows on the read port.
  assign rd_data = rd_valid ? mem[rd_ptr_reg] : '0;
  assign level   = level_reg;

endmodule

// File: rtl/pyhdl_via_stream_capture.sv
// Capture stage: timestamps accepted beats, gates them through an
// arm/trigger/limit FSM and buffers them for the VIA drain port.
module pyhdl_via_stream_capture
  import pyhdl_via_capture_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 16,
  parameter int LIMIT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  pyhdl_via_stream_capture_if.slave bus,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      trig_mask,
  input  logic [DATA_W-1:0]      trig_value,
  input  logic [LIMIT_W-1:0]     cap_limit,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow,
  output logic [1:0]             state
);
  localparam int EW = TS_W + DATA_W;

  cap_state_e         state_reg, state_next;
  logic [LIMIT_W-1:0] count_reg, count_next;
  logic [LIMIT_W-1:0] limit_reg, limit_next;
  logic [LIMIT_W-1:0] count_inc;
  logic [TS_W-1:0]    ts_reg;
  logic [DROP_W-1:0]  drop_cnt_reg;
  logic               overflow_reg;
  logic               beat, hit, capture, pop, full, drop;
  logic [EW-1:0]      head;

  assign beat      = bus.mon_valid && bus.mon_ready;
  assign hit       = beat && ((bus.mon_data & trig_mask) == (trig_value & trig_mask));
  assign count_inc = count_reg + LIMIT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      limit_reg <= '0;
      ts_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      limit_reg <= limit_next;
      ts_reg    <= ts_reg + TS_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    limit_next = limit_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
          count_next = '0;
        end
      end
      ARMED: begin
        if (hit) begin
          // Trigger beat is captured beat 1; the limit is frozen here.
          capture    = 1'b1;
          count_next = LIMIT_W'(1);
          limit_next = cap_limit;
          state_next = (stop || cap_limit == LIMIT_W'(1)) ? DONE : RUN;
        end else if (stop) begin
          state_next = DONE;
        end
      end
      RUN: begin
        if (beat) begin
          capture    = 1'b1;
          count_next = count_inc;
          if (limit_reg != '0 && count_inc == limit_reg) state_next = DONE;
        end
        if (stop) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          state_next = ARMED;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop  = bus.rd_valid && bus.rd_ready;
  assign drop = capture && full && !pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end
  end

  pyhdl_via_fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (capture),
    .pop      (pop),
    .wr_data  ({ts_reg, bus.mon_data}),
    .rd_data  (head),
    .rd_valid (bus.rd_valid),
    .full     (full),
    .level    (level)
  );

  assign bus.rd_ts   = head[EW-1:DATA_W];
  assign bus.rd_data = head[DATA_W-1:0];
  assign drop_cnt    = drop_cnt_reg;
  assign overflow    = overflow_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_pyhdl_via_stream_capture.sv
// Scoreboard bench: stimulus queues expected {ts,data} entries, a negedge
// monitor checks each entry as it is drained from the read port.
module tb_pyhdl_via_stream_capture;
  localparam int DATA_W = 32;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 4;
  localparam int LW     = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] trig_mask = '0, trig_value = '0;
  logic [LW-1:0]     cap_limit = '0;
  logic [2:0]        level;
  logic [15:0]       drop_cnt;
  logic              overflow;
  logic [1:0]        state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [TS_W+DATA_W-1:0] expq [$];

  pyhdl_via_stream_capture_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  pyhdl_via_stream_capture #(
    .DATA_W (DATA_W), .TS_W (TS_W), .DEPTH (DEPTH), .LIMIT_W (LW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .start      (start),
    .stop       (stop),
    .flush      (flush),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .cap_limit  (cap_limit),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .state      (state)
  );

  always #5 clock = ~clock;

  // Reference cycle count: number of clock edges since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc = 0;
    else cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (reset_n && bus.rd_valid && bus.rd_ready) begin
      logic [TS_W+DATA_W-1:0] e;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got ts=%0d data=%h, required no entry", bus.rd_ts, bus.rd_data);
      end else begin
        e = expq.pop_front();
        if ({bus.rd_ts, bus.rd_data} !== e) begin
          bad++;
          $display("FAIL pop_entry: got ts=%0d data=%h, required ts=%0d data=%h",
                   bus.rd_ts, bus.rd_data, e[TS_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end else begin
          $display("pop ok: ts=%0d data=%h", bus.rd_ts, bus.rd_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input bit cap);
    logic [TS_W-1:0] t;
    t = cyc[TS_W-1:0];
    bus.mon_valid = 1'b1; bus.mon_ready = 1'b1; bus.mon_data = d;
    if (cap) expq.push_back({t, d});
    tick();
    bus.mon_valid = 1'b0; bus.mon_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.rd_ready = 1'b1;
    repeat (n) tick();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.mon_valid = 1'b0; bus.mon_ready = 1'b0; bus.mon_data = '0; bus.rd_ready = 1'b0;
    repeat (2) tick();
    check("reset_state", 64'(state), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("reset_rd_data", 64'(bus.rd_data), 64'd0);
    check("reset_rd_ts", 64'(bus.rd_ts), 64'd0);
    check("reset_drop", 64'(drop_cnt), 64'd0);
    reset_n = 1'b1;
    tick();

    // Trigger on 0x5A, limit 3.
    trig_mask = 32'hFF; trig_value = 32'h5A; cap_limit = 16'd3;
    pulse_start();
    check("armed_state", 64'(state), 64'd1);
    beat(32'h11, 1'b0);
    check("no_trig_state", 64'(state), 64'd1);
    beat(32'h5A, 1'b1);
    check("run_state", 64'(state), 64'd2);
    beat(32'h22, 1'b1);
    beat(32'h33, 1'b1);
    check("limit_done_state", 64'(state), 64'd3);
    beat(32'h44, 1'b0);
    check("limit_level", 64'(level), 64'd3);
    drain(3);
    check("drain_level", 64'(level), 64'd0);

    // Overflow with any-beat trigger, then flush.
    trig_mask = '0; cap_limit = '0;
    pulse_start();
    for (int i = 0; i < 6; i++) beat(32'h100 + 32'(i), i < 4);
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(overflow), 64'd1);
    flush = 1'b1; expq.delete(); tick(); flush = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_drop", 64'(drop_cnt), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd0);
    check("flush_state", 64'(state), 64'd2);

    // Full with simultaneous pop and push.
    for (int i = 0; i < 4; i++) beat(32'h200 + 32'(i), 1'b1);
    bus.rd_ready = 1'b1;
    beat(32'h2FF, 1'b1);
    bus.rd_ready = 1'b0;
    check("full_pp_level", 64'(level), 64'd4);
    check("full_pp_drop", 64'(drop_cnt), 64'd0);
    drain(4);
    check("full_pp_drain", 64'(level), 64'd0);
    pulse_stop();
    check("stop_state", 64'(state), 64'd3);

    // Hit and stop on the same edge, then re-arm.
    pulse_start();
    trig_mask = 32'hFF; trig_value = 32'h77; cap_limit = 16'd5;
    stop = 1'b1;
    beat(32'h77, 1'b1);
    stop = 1'b0;
    check("hitstop_state", 64'(state), 64'd3);
    check("hitstop_level", 64'(level), 64'd1);
    pulse_start();
    check("rearm_state", 64'(state), 64'd1);
    cap_limit = 16'd2;
    beat(32'h177, 1'b1);
    check("rearm_run", 64'(state), 64'd2);
    cap_limit = 16'd0;
    beat(32'h88, 1'b1);
    check("rearm_limit_done", 64'(state), 64'd3);
    check("rearm_level", 64'(level), 64'd3);
    drain(3);
    check("queue_empty", 64'(expq.size()), 64'd0);

    // Timestamp wrap and first-word latency after a fresh reset.
    reset_n = 1'b0;
    expq.delete();
    tick();
    reset_n = 1'b1;
    pulse_start();
    trig_mask = '0;
    for (int g = 0; g < 100 && cyc != 17; g++) tick();
    check("wrap_cycle_reached", 64'(cyc), 64'd17);
    check("lat_before", 64'(bus.rd_valid), 64'd0);
    beat(32'hAB, 1'b1);
    check("lat_after", 64'(bus.rd_valid), 64'd1);
    check("wrap_ts", 64'(bus.rd_ts), 64'd1);
    check("wrap_data", 64'(bus.rd_data), 64'hAB);
    beat(32'hCD, 1'b1);
    check("mid_run_level", 64'(level), 64'd2);
    check("mid_run_state", 64'(state), 64'd2);

    // Asynchronous reset between edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_state", 64'(state), 64'd0);
    check("async_rd_data", 64'(bus.rd_data), 64'd0);
    expq.delete();
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
